// File: rtl/alu_result_tx.sv
// ALU result transmitter: buffers {carry,res} in a small FIFO and ships each result
// to the host as two bytes over a 4-phase strobe/acknowledge link.
module alu_result_tx #(
    parameter int FIFO_DEPTH  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       res_valid,
    output logic       res_ready,
    input  logic [9:0] res_d,
    input  logic       carry_d,
    output logic [7:0] out_data,
    output logic       out_stb,
    input  logic       ack_in,
    output logic       busy,
    output logic [3:0] seq
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, STB_HI, STB_LO} state_t;

    logic [1:0]             r_rst_sync;
    logic                   w_rst_n;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic                   w_ack_s;
    logic [10:0]            r_mem [FIFO_DEPTH];
    logic [PW-1:0]          r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic                   w_push, w_pop;
    state_t                 r_state;
    logic [10:0]            r_hold;
    logic                   r_byte_idx;
    logic [7:0]             r_out_data;
    logic                   r_out_stb;
    logic [3:0]             r_seq;

    // Assertion is asynchronous; release is retimed so all state leaves reset on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= '0;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ack_sync <= '0;
        else        r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack_in};
    end
    assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

    assign res_ready = (r_count != CW'(FIFO_DEPTH));
    assign w_push    = res_valid && res_ready;
    // Holding off while ack_s is still high keeps the strobe from rising into a stale ack.
    assign w_pop     = (r_state == IDLE) && (r_count != '0) && !w_ack_s;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {carry_d, res_d};
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= (r_wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= IDLE;
            r_hold     <= '0;
            r_byte_idx <= 1'b0;
            r_out_data <= '0;
            r_out_stb  <= 1'b0;
            r_seq      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_hold     <= r_mem[r_rd_ptr];
                        r_out_data <= r_mem[r_rd_ptr][7:0];
                        r_out_stb  <= 1'b1;
                        r_byte_idx <= 1'b0;
                        r_state    <= STB_HI;
                    end
                end
                STB_HI: begin
                    if (w_ack_s) begin
                        r_out_stb <= 1'b0;
                        r_state   <= STB_LO;
                    end
                end
                STB_LO: begin
                    if (!w_ack_s) begin
                        if (!r_byte_idx) begin
                            r_out_data <= {r_seq, 1'b0, r_hold[10], r_hold[9:8]};
                            r_out_stb  <= 1'b1;
                            r_byte_idx <= 1'b1;
                            r_state    <= STB_HI;
                        end else begin
                            r_seq   <= r_seq + 1'b1;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_data = r_out_data;
    assign out_stb  = r_out_stb;
    assign seq      = r_seq;
    assign busy     = (r_count != '0) || (r_state != IDLE);
endmodule

// File: tb/tb_alu_result_tx.sv
// Randomized scoreboard bench for alu_result_tx: expected host bytes are queued at push
// time and popped by a monitor on every rising strobe; a host model answers the strobes.
module tb_alu_result_tx;
    logic       clk, rst_n, res_valid, res_ready, carry_d, out_stb, ack_in, busy;
    logic [9:0] res_d;
    logic [7:0] out_data;
    logic [3:0] seq;

    alu_result_tx #(.FIFO_DEPTH(2), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .res_ready(res_ready),
        .res_d(res_d), .carry_d(carry_d), .out_data(out_data), .out_stb(out_stb),
        .ack_in(ack_in), .busy(busy), .seq(seq)
    );

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    int         mseq = 0;          // next sequence number the host should see
    int         ack_mode = 0;      // 0: host answers after ack_dly cycles, 1: ack forced to ack_val
    logic       ack_val = 1'b0;
    int         ack_dly = 3;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Host model: 4-phase acknowledge after a programmable delay.
    initial begin
        int cnt;
        cnt = 0;
        ack_in = 1'b0;
        forever begin
            @(negedge clk);
            if (ack_mode == 1) begin
                ack_in = ack_val;
                cnt = 0;
            end else if (out_stb !== ack_in) begin
                if (cnt >= ack_dly) begin
                    ack_in = out_stb;
                    cnt = 0;
                end else cnt++;
            end else cnt = 0;
        end
    end

    // Monitor: every rising strobe must deliver the next byte; data holds while strobe is high.
    initial begin
        logic       prev_stb;
        logic [7:0] prev_data;
        logic [7:0] e;
        prev_stb = 1'b0;
        prev_data = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && out_stb && !prev_stb) begin
                if (exp_q.size() == 0) chk("unexpected_byte", {24'h0, out_data}, 32'hFFFF_FFFF);
                else begin
                    e = exp_q.pop_front();
                    chk("byte", {24'h0, out_data}, {24'h0, e});
                end
            end else if (rst_n && out_stb && prev_stb) begin
                chk("data_stable_while_stb", {24'h0, out_data}, {24'h0, prev_data});
            end
            prev_stb = out_stb;
            prev_data = out_data;
        end
    end

    task automatic push_res(input logic [9:0] r, input logic c);
        int n;
        n = 0;
        @(negedge clk);
        res_valid = 1'b1;
        res_d = r;
        carry_d = c;
        while (!res_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!res_ready) chk("push_timeout", 32'd0, 32'd1);
        else begin
            exp_q.push_back(r[7:0]);
            exp_q.push_back({mseq[3:0], 1'b0, c, r[9:8]});
            mseq = (mseq + 1) % 16;
        end
        @(posedge clk);
        #1;
        res_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && !busy && !out_stb) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_done", {31'h0, exp_q.size() == 0 && !busy}, 32'd1);
        chk("seq_after_drain", {28'h0, seq}, mseq);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        res_valid = 1'b0;
        res_d = '0;
        carry_d = 1'b0;
        do_reset();
        chk("rst_out_stb", {31'h0, out_stb}, 0);
        chk("rst_out_data", {24'h0, out_data}, 0);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_seq", {28'h0, seq}, 0);
        chk("rst_res_ready", {31'h0, res_ready}, 1);

        // Single result, host acks after 3 cycles.
        push_res(10'h2A5, 1'b1);
        drain();

        // Three pushes with ack held low: one popped, two left in a full FIFO.
        mseq = 1;
        ack_mode = 1;
        ack_val = 1'b0;
        push_res(10'h101, 1'b0);
        push_res(10'h202, 1'b1);
        push_res(10'h303, 1'b0);
        chk("full_res_ready", {31'h0, res_ready}, 0);
        chk("full_busy", {31'h0, busy}, 1);
        ack_mode = 0;
        n = 0;
        while (!res_ready && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ready_back_after_first", {31'h0, res_ready}, 1);
        chk("ready_back_queue_left", exp_q.size(), 4);
        drain();

        // 17 results: sequence number wraps.
        for (int i = 0; i < 17; i++) push_res(10'($urandom), 1'($urandom));
        drain();

        // Ack stuck high after the first strobe: no new strobe, data held.
        ack_mode = 1;
        ack_val = 1'b0;
        push_res(10'h2A5, 1'b1);
        n = 0;
        while (!out_stb && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        ack_val = 1'b1;
        repeat (12) @(negedge clk);
        chk("stuck_ack_stb_low", {31'h0, out_stb}, 0);
        chk("stuck_ack_data_held", {24'h0, out_data}, 32'hA5);
        chk("stuck_ack_busy", {31'h0, busy}, 1);
        chk("stuck_ack_queue", exp_q.size(), 1);
        ack_mode = 0;
        drain();

        // Reset while byte1 of the first of two results is strobed.
        push_res(10'h1C3, 1'b0);
        push_res(10'h0F0, 1'b1);
        n = 0;
        while (!(exp_q.size() == 2 && out_stb) && n < 500) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("reached_byte1", {31'h0, out_stb}, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_stb", {31'h0, out_stb}, 0);
        chk("midrst_seq", {28'h0, seq}, 0);
        chk("midrst_busy", {31'h0, busy}, 0);
        chk("midrst_res_ready", {31'h0, res_ready}, 1);
        exp_q.delete();
        mseq = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        push_res(10'h2A5, 1'b1);
        drain();

        // Random results, gaps and host latency; pushes overlap pops.
        for (int i = 0; i < 30; i++) begin
            ack_dly = $urandom_range(0, 2);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            push_res(10'($urandom), 1'($urandom));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
